// File: rtl/pqsdn_ram_arb.sv
// Two-writer / two-reader round-robin front end for a simple dual-port RAM.
// Reads are held off while the addressed word has a write in flight, so no stale data is returned.
module pqsdn_ram_arb #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 10,
  parameter int EN_W   = DATA_W/8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          wr_valid_i,
  output logic [1:0]          wr_ready_o,
  input  logic [2*ADDR_W-1:0] wr_addr_i,
  input  logic [2*DATA_W-1:0] wr_data_i,
  input  logic [2*EN_W-1:0]   wr_be_i,
  input  logic [1:0]          rd_valid_i,
  output logic [1:0]          rd_ready_o,
  input  logic [2*ADDR_W-1:0] rd_addr_i,
  output logic [1:0]          rd_rvalid_o,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                ram_en_a_o,
  output logic [EN_W-1:0]     ram_wren_a_o,
  output logic [ADDR_W-1:0]   ram_wraddr_a_o,
  output logic [DATA_W-1:0]   ram_wrdata_a_o,
  output logic                ram_rden_b_o,
  output logic [ADDR_W-1:0]   ram_rdaddr_b_o,
  input  logic [DATA_W-1:0]   ram_rddata_i,
  output logic [15:0]         hzd_cnt_o
);

  logic              r_wr_last, r_rd_last;
  logic              r_pend_vld;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [1:0]        r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [15:0]       r_hzd;

  logic [1:0]        w_wr_req, w_rd_req, w_rd_elig, w_blk;
  logic              w_wr_any, w_wr_sel, w_rd_any, w_rd_sel;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_win_addr;
  logic [ADDR_W-1:0] w_rd_addr [2];

  // Requests are masked during reset so nothing is granted and all outputs read 0.
  assign w_wr_req = rst_n ? wr_valid_i : 2'b00;
  assign w_rd_req = rst_n ? rd_valid_i : 2'b00;

  // Single requester wins outright; on contention the one not served last goes.
  assign w_wr_any  = |w_wr_req;
  assign w_wr_sel  = (w_wr_req == 2'b11) ? ~r_wr_last : w_wr_req[1];
  assign w_wr_addr = w_wr_sel ? wr_addr_i[2*ADDR_W-1:ADDR_W] : wr_addr_i[ADDR_W-1:0];

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_rd
      assign w_rd_addr[g] = rd_addr_i[g*ADDR_W +: ADDR_W];
      // Covers both the write landing this cycle and the one still settling from last cycle.
      assign w_blk[g] = (w_wr_any   && (w_rd_addr[g] == w_wr_addr)) ||
                        (r_pend_vld && (w_rd_addr[g] == r_pend_addr));
    end
  endgenerate

  assign w_rd_elig     = w_rd_req & ~w_blk;
  assign w_rd_any      = |w_rd_elig;
  assign w_rd_sel      = (w_rd_elig == 2'b11) ? ~r_rd_last : w_rd_elig[1];
  assign w_rd_win_addr = w_rd_sel ? w_rd_addr[1] : w_rd_addr[0];

  assign wr_ready_o     = {w_wr_any & w_wr_sel, w_wr_any & ~w_wr_sel};
  assign ram_en_a_o     = w_wr_any;
  assign ram_wren_a_o   = !w_wr_any ? '0 :
                          (w_wr_sel ? wr_be_i[2*EN_W-1:EN_W] : wr_be_i[EN_W-1:0]);
  assign ram_wraddr_a_o = w_wr_any ? w_wr_addr : '0;
  assign ram_wrdata_a_o = !w_wr_any ? '0 :
                          (w_wr_sel ? wr_data_i[2*DATA_W-1:DATA_W] : wr_data_i[DATA_W-1:0]);

  assign rd_ready_o     = {w_rd_any & w_rd_sel, w_rd_any & ~w_rd_sel};
  assign ram_rden_b_o   = w_rd_any;
  assign ram_rdaddr_b_o = w_rd_any ? w_rd_win_addr : '0;

  // Registered outputs are forced low while reset is held, before the sync clear lands.
  assign rd_rvalid_o = rst_n ? r_rvalid : 2'b00;
  assign rd_data_o   = rst_n ? r_rdata  : '0;
  assign hzd_cnt_o   = rst_n ? r_hzd    : 16'h0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_last   <= 1'b1;
      r_rd_last   <= 1'b1;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_rvalid    <= 2'b00;
      r_rdata     <= '0;
      r_hzd       <= 16'h0;
    end else begin
      r_pend_vld <= w_wr_any;
      if (w_wr_any) begin
        r_pend_addr <= w_wr_addr;
        r_wr_last   <= w_wr_sel;
      end
      r_rvalid <= rd_ready_o;
      if (w_rd_any) begin
        r_rdata   <= ram_rddata_i;
        r_rd_last <= w_rd_sel;
      end
      if (|(w_rd_req & w_blk) && (r_hzd != 16'hFFFF))
        r_hzd <= r_hzd + 16'd1;
    end
  end

endmodule

// File: tb/tb_pqsdn_ram_arb.sv
// Bench for pqsdn_ram_arb: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (round-robin picks, one-deep write history, word memory).
module tb_pqsdn_ram_arb;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int EW = DW/8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]    wr_valid, rd_valid;
  logic [AW-1:0] t_waddr [2];
  logic [DW-1:0] t_wdata [2];
  logic [EW-1:0] t_wbe   [2];
  logic [AW-1:0] t_raddr [2];

  logic [1:0]    wr_ready, rd_ready, rd_rvalid;
  logic [DW-1:0] rd_data, ram_wrdata, ram_rddata;
  logic          ram_en, ram_rden;
  logic [EW-1:0] ram_wren;
  logic [AW-1:0] ram_wraddr, ram_rdaddr;
  logic [15:0]   hzd_cnt;

  pqsdn_ram_arb #(.DATA_W(DW), .ADDR_W(AW), .EN_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_addr_i({t_waddr[1], t_waddr[0]}), .wr_data_i({t_wdata[1], t_wdata[0]}),
    .wr_be_i({t_wbe[1], t_wbe[0]}),
    .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_i({t_raddr[1], t_raddr[0]}),
    .rd_rvalid_o(rd_rvalid), .rd_data_o(rd_data),
    .ram_en_a_o(ram_en), .ram_wren_a_o(ram_wren), .ram_wraddr_a_o(ram_wraddr),
    .ram_wrdata_a_o(ram_wrdata), .ram_rden_b_o(ram_rden), .ram_rdaddr_b_o(ram_rdaddr),
    .ram_rddata_i(ram_rddata), .hzd_cnt_o(hzd_cnt)
  );

  // Physical RAM driven only by the DUT's ports.
  logic [DW-1:0] ram [1<<AW];
  assign ram_rddata = ram[ram_rdaddr];
  always @(posedge clk)
    if (ram_en)
      for (int b = 0; b < EW; b++)
        if (ram_wren[b]) ram[ram_wraddr][8*b +: 8] <= ram_wrdata[8*b +: 8];

  // Reference model state
  logic [DW-1:0] m_mem [1<<AW];
  int            m_wlast, m_rlast, m_hzd;
  bit            m_pv;
  logic [AW-1:0] m_pa;
  logic [1:0]    m_rv;
  logic [DW-1:0] m_rd;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [1:0] v, input int last);
    if (v == 2'b11) return 1 - last;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  // One clock: compare at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    int ww, rw;
    logic [1:0] blk;
    @(negedge clk);
    ww = -1; rw = -1; blk = 2'b00;
    if (!rst_n) begin
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_ready", rd_ready, 0);
      chk("rst_ram_en", {ram_en, ram_wren, ram_rden}, 0);
      chk("rst_addrs", {ram_wraddr, ram_rdaddr}, 0);
      chk("rst_wrdata", ram_wrdata, 0);
      chk("rst_rvalid", rd_rvalid, 0);
      chk("rst_rdata", rd_data, 0);
      chk("rst_hzd", hzd_cnt, 0);
    end else begin
      ww = rr_pick(wr_valid, m_wlast);
      for (int i = 0; i < 2; i++)
        blk[i] = rd_valid[i] && ((ww >= 0 && t_raddr[i] == t_waddr[ww]) ||
                                 (m_pv && t_raddr[i] == m_pa));
      rw = rr_pick(rd_valid & ~blk, m_rlast);
      chk("wr_ready", wr_ready, (ww < 0) ? 0 : (1 << ww));
      chk("rd_ready", rd_ready, (rw < 0) ? 0 : (1 << rw));
      chk("ram_en", ram_en, ww >= 0);
      chk("ram_rden", ram_rden, rw >= 0);
      if (ww >= 0) begin
        chk("ram_wraddr", ram_wraddr, t_waddr[ww]);
        chk("ram_wrdata", ram_wrdata, t_wdata[ww]);
        chk("ram_wren", ram_wren, t_wbe[ww]);
      end else
        chk("ram_wren_idle", ram_wren, 0);
      if (rw >= 0) chk("ram_rdaddr", ram_rdaddr, t_raddr[rw]);
      chk("rd_rvalid", rd_rvalid, m_rv);
      chk("rd_data", rd_data, m_rd);
      chk("hzd_cnt", hzd_cnt, m_hzd);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_wlast = 1; m_rlast = 1; m_pv = 0; m_pa = '0;
      m_rv = 2'b00; m_rd = '0; m_hzd = 0;
    end else begin
      if (rw >= 0) begin
        m_rd = m_mem[t_raddr[rw]];
        m_rv = 2'b01 << rw;
        m_rlast = rw;
      end else
        m_rv = 2'b00;
      if ((|blk) && m_hzd < 65535) m_hzd++;
      if (ww >= 0) begin
        for (int b = 0; b < EW; b++)
          if (t_wbe[ww][b]) m_mem[t_waddr[ww]][8*b +: 8] = t_wdata[ww][8*b +: 8];
        m_wlast = ww; m_pv = 1; m_pa = t_waddr[ww];
      end else
        m_pv = 0;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  task automatic idle();
    wr_valid = 2'b00; rd_valid = 2'b00;
  endtask

  initial begin
    for (int a = 0; a < (1<<AW); a++) begin ram[a] = '0; m_mem[a] = '0; end
    m_wlast = 1; m_rlast = 1; m_pv = 0; m_pa = '0; m_rv = 2'b00; m_rd = '0; m_hzd = 0;
    for (int i = 0; i < 2; i++) begin
      t_waddr[i] = '0; t_wdata[i] = '0; t_wbe[i] = '0; t_raddr[i] = '0;
    end
    wr_valid = 2'b11; rd_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    do_reset(2);
    idle();
    cycle();

    // Both writers contending on 0x10..0x13
    for (int k = 0; k < 4; k++) begin
      wr_valid = 2'b11;
      for (int i = 0; i < 2; i++) begin
        t_waddr[i] = AW'(8'h10 + k);
        t_wdata[i] = $urandom;
        t_wbe[i]   = EW'($urandom);
      end
      cycle();
    end
    idle(); cycle(); cycle();

    // Read-after-write hazard on 0x20
    do_reset(1);
    wr_valid = 2'b01; t_waddr[0] = 6'h20; t_wdata[0] = 32'hA5A5A5A5; t_wbe[0] = 4'hF;
    rd_valid = 2'b01; t_raddr[0] = 6'h20;
    cycle();
    wr_valid = 2'b00;
    cycle();
    cycle();
    rd_valid = 2'b00;
    chk("raw_rvalid", rd_rvalid, 2'b01);
    chk("raw_data", rd_data, 32'hA5A5A5A5);
    chk("raw_hzd", hzd_cnt, 16'd2);
    cycle();

    // Blocked reader 0 must not stall reader 1
    wr_valid = 2'b01; t_waddr[0] = 6'h20; t_wdata[0] = 32'h1234_5678; t_wbe[0] = 4'h3;
    rd_valid = 2'b11; t_raddr[0] = 6'h20; t_raddr[1] = 6'h30;
    cycle();
    idle();
    chk("bypass_rvalid", rd_rvalid, 2'b10);
    cycle(); cycle();

    // Back-to-back contending reads
    for (int k = 0; k < 6; k++) begin
      rd_valid = 2'b11;
      t_raddr[0] = AW'(k); t_raddr[1] = AW'(8 + k);
      cycle();
    end
    idle(); cycle(); cycle();

    // Reset right after a read grant drops the response
    rd_valid = 2'b01; t_raddr[0] = 6'h05;
    cycle();
    rd_valid = 2'b11;
    do_reset(1);
    idle();
    chk("post_rst_rvalid", rd_rvalid, 2'b00);
    rd_valid = 2'b11; t_raddr[0] = 6'h01; t_raddr[1] = 6'h02;
    cycle();
    chk("post_rst_winner", rd_rvalid, 2'b01);
    idle(); cycle();

    // Random traffic on a small address window to provoke hazards
    for (int k = 0; k < 1500; k++) begin
      wr_valid = 2'($urandom); rd_valid = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        t_waddr[i] = AW'($urandom_range(0, 7));
        t_raddr[i] = AW'($urandom_range(0, 7));
        t_wdata[i] = $urandom;
        t_wbe[i]   = EW'($urandom);
      end
      rst_n = ($urandom_range(0, 49) != 0);
      cycle();
    end
    rst_n = 1'b1;
    idle(); cycle();

    // Continuous hazard to saturate the stall counter
    do_reset(1);
    wr_valid = 2'b01; t_waddr[0] = 6'h05; t_wbe[0] = 4'hF;
    rd_valid = 2'b01; t_raddr[0] = 6'h05;
    for (int k = 0; k < 70000; k++) begin
      t_wdata[0] = $urandom;
      cycle();
    end
    chk("hzd_sat", hzd_cnt, 16'hFFFF);
    idle(); cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
